pipe_bus_arbiter: RTL and testbench
===================================

Name: pipe_bus_arbiter

Overview:
- Shares one external memory bus (Wishbone-style cyc/stb/ack) between the instruction-fetch port (pc_reg/if_id side) and the data port (mem stage).
- Sequences each access as a multi-cycle transaction and drives the 6-bit pipeline stall vector while a requester waits.
- Sits beside the five-stage core; it replaces the direct ROM connection and the separate data RAM connection.

Parameters:
- TIMEOUT_CYCLES, 255: bus-ack wait limit. Used only with BUS_TIMEOUT_EN.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk in 1: single clock. All logic is on the rising edge.
- rst in 1: reset, asynchronous, active-low.
- if_req_i in 1: fetch request, held until if_ack_o.
- if_addr_i in 32: fetch address.
- if_data_o out 32: fetched instruction.
- if_ack_o out 1: one-cycle completion pulse for fetch.
- mem_req_i in 1: data request, held until mem_ack_o.
- mem_we_i in 1: 1 = store.
- mem_addr_i in 32: data address.
- mem_data_i in 32: store data.
- mem_sel_i in 4: byte enables.
- mem_data_o out 32: load data.
- mem_ack_o out 1: one-cycle completion pulse for data.
- bus_cyc_o out 1, bus_stb_o out 1: bus cycle/strobe.
- bus_we_o out 1: bus write enable.
- bus_addr_o out 32: bus address.
- bus_data_o out 32: bus write data.
- bus_sel_o out 4: bus byte enables.
- bus_data_i in 32: bus read data.
- bus_ack_i in 1: bus completion.
- stall_o out 6: bit 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
- bus_err_o out 1: timeout pulse.

Behaviour:
- Reset (rst low, takes effect immediately, no clock needed):
  - State = IDLE, last_gnt = FETCH, timeout counter = 0.
  - All bus_* outputs = 0, both acks = 0, both data outputs = 0, bus_err_o = 0.
- States: IDLE, IF_WAIT, MEM_WAIT.
- IDLE grant decision:
  - Only mem_req_i: go to MEM_WAIT.
  - Only if_req_i: go to IF_WAIT.
  - Both: MEM wins unless last_gnt == MEM, then FETCH wins. Alternation prevents starvation.
  - A request is never granted in the same cycle as its own ack pulse. This gives one turnaround cycle, so there is at most one access per 2 cycles per requester.
- On grant, the bus outputs are registered from the requester's inputs on the transition edge:
  - cyc = stb = 1.
  - Fetch: we = 0, sel = 4'hF, bus_data_o = 0.
  - Data: we, addr, data and sel are taken from mem_*.
  - Bus outputs are held constant for the whole WAIT state.
- WAIT, when bus_ack_i = 1:
  - Drop cyc/stb on the next edge.
  - Latch bus_data_i into the granted port's data_o (stores latch 0).
  - Pulse that port's ack for exactly one cycle.
  - Update last_gnt; return to IDLE.
- Abandoned request: if the granted requester's req is low when bus_ack_i arrives (pipeline flush), the bus transaction still completes. The ack and the data update are suppressed.
- data_o holds its value until the next ack of the same port.
- stall_o is combinational:
  - mem_req_i & ~mem_ack_o gives 6'b011111.
  - Otherwise if_req_i & ~if_ack_o gives 6'b000011.
  - Otherwise 6'b000000.
  - A data stall overrides a fetch stall.
- bus_ack_i outside WAIT is ignored.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop cyc/stb, pulse bus_err_o and the granted port's ack for one cycle with data_o = 0, update last_gnt, go to IDLE.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- Undefined: WAIT is unbounded, there is no counter, and bus_err_o is tied to 0. The port is always present.

Decomposition:
- Shared defines file: state encodings, stall vector constants STALL_NONE/STALL_IF/STALL_MEM, and the grant-id constants. Bus widths use RegBus/InstAddrBus.
- No sub-module needed. The optional timeout counter stays inline.

Test Plan:
1. Async reset mid-access: assert rst low in MEM_WAIT between clock edges -> bus_cyc_o = 0 immediately, and after release the state is IDLE with all outputs 0.
2. Fetch only: if_req_i = 1, addr 0x00000010, bus ack after 3 cycles with 0x3401FF00 -> if_data_o = 0x3401FF00, if_ack_o is a single pulse, stall_o = 000011 while waiting.
3. Store: mem_req_i = 1, we = 1, addr 0x100, data 0xDEADBEEF, sel 4'b0011 -> bus outputs match for the whole access, stall_o = 011111, mem_ack_o pulses once.
4. Simultaneous requests held high -> grant order MEM, FETCH, MEM, FETCH, with one idle cycle between accesses.
5. Flush: drop if_req_i during IF_WAIT -> transaction completes, no if_ack_o, if_data_o unchanged.
6. With BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 4, never ack -> after 4 WAIT cycles bus_err_o and mem_ack_o pulse, mem_data_o = 0, cyc drops. Repeat with ack on cycle 4 -> no error.

Source files
------------

// File: rtl/pipe_bus_arbiter_pkg.sv
// Shared definitions for pipe_bus_arbiter: bus widths, FSM state encoding,
// grant identifiers and the pipeline stall vector constants.
package pipe_bus_arbiter_pkg;

  localparam int RegBus      = 32;
  localparam int InstAddrBus = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_MEM   = 1'b1
  } gnt_e;

  // Stall vector bits: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/pipe_bus_arbiter.sv
// pipe_bus_arbiter: shares one Wishbone-style bus between the instruction
// fetch port and the data port of the five-stage core. Each access is a
// multi-cycle transaction; stall_o holds the pipeline while a requester waits.
// Optional feature macro: BUS_TIMEOUT_EN (bounds the ack wait to
// TIMEOUT_CYCLES and reports expiry on bus_err_o). Without it the wait is
// unbounded and bus_err_o stays 0.
module pipe_bus_arbiter
  import pipe_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req_i,
  input  logic [InstAddrBus-1:0] if_addr_i,
  output logic [RegBus-1:0]      if_data_o,
  output logic                   if_ack_o,
  input  logic                   mem_req_i,
  input  logic                   mem_we_i,
  input  logic [RegBus-1:0]      mem_addr_i,
  input  logic [RegBus-1:0]      mem_data_i,
  input  logic [3:0]             mem_sel_i,
  output logic [RegBus-1:0]      mem_data_o,
  output logic                   mem_ack_o,
  output logic                   bus_cyc_o,
  output logic                   bus_stb_o,
  output logic                   bus_we_o,
  output logic [RegBus-1:0]      bus_addr_o,
  output logic [RegBus-1:0]      bus_data_o,
  output logic [3:0]             bus_sel_o,
  input  logic [RegBus-1:0]      bus_data_i,
  input  logic                   bus_ack_i,
  output logic [5:0]             stall_o,
  output logic                   bus_err_o
);

  // The counter must be able to hold the limit.
  if (TIMEOUT_CYCLES >= (2 ** CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too small for TIMEOUT_CYCLES");
  end

  arb_state_e state;
  gnt_e       last_gnt;

  // A requester is eligible only outside the cycle of its own ack pulse,
  // which forces one turnaround cycle between its accesses.
  logic if_ok;
  logic mem_ok;
  logic gnt_mem;
  logic timeout;

  assign if_ok   = if_req_i  & ~if_ack_o;
  assign mem_ok  = mem_req_i & ~mem_ack_o;
  assign gnt_mem = mem_ok & (~if_ok | (last_gnt != GNT_MEM));

`ifdef BUS_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt;

  // Count WAIT cycles without ack; held at zero while idle so every
  // transaction starts from a cleared count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == ST_IDLE) begin
      tmo_cnt <= '0;
    end else if (!bus_ack_i) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Fires on the last permitted WAIT cycle; an ack in that cycle wins.
  assign timeout = (state != ST_IDLE) && !bus_ack_i &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Grant, bus sequencing and completion; all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_gnt   <= GNT_FETCH;
      bus_cyc_o  <= 1'b0;
      bus_stb_o  <= 1'b0;
      bus_we_o   <= 1'b0;
      bus_addr_o <= '0;
      bus_data_o <= '0;
      bus_sel_o  <= '0;
      if_ack_o   <= 1'b0;
      mem_ack_o  <= 1'b0;
      if_data_o  <= '0;
      mem_data_o <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden later in the same
      // block, so acks and the error flag become single-cycle pulses.
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      bus_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_mem) begin
            state      <= ST_MEM_WAIT;
            bus_cyc_o  <= 1'b1;
            bus_stb_o  <= 1'b1;
            bus_we_o   <= mem_we_i;
            bus_addr_o <= mem_addr_i;
            bus_data_o <= mem_data_i;
            bus_sel_o  <= mem_sel_i;
          end else if (if_ok) begin
            state      <= ST_IF_WAIT;
            bus_cyc_o  <= 1'b1;
            bus_stb_o  <= 1'b1;
            bus_we_o   <= 1'b0;
            bus_addr_o <= if_addr_i;
            bus_data_o <= '0;
            bus_sel_o  <= 4'hF;
          end
        end
        ST_IF_WAIT, ST_MEM_WAIT: begin
          if (bus_ack_i || timeout) begin
            state     <= ST_IDLE;
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            bus_err_o <= timeout;
            // A flushed requester still lets the bus finish, but sees no
            // ack and keeps its previous data.
            if (state == ST_MEM_WAIT) begin
              last_gnt <= GNT_MEM;
              if (mem_req_i) begin
                mem_ack_o  <= 1'b1;
                mem_data_o <= (bus_ack_i && !bus_we_o) ? bus_data_i : '0;
              end
            end else begin
              last_gnt <= GNT_FETCH;
              if (if_req_i) begin
                if_ack_o  <= 1'b1;
                if_data_o <= bus_ack_i ? bus_data_i : '0;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pipeline stall: a waiting data access freezes everything up to mem,
  // a waiting fetch only freezes pc and if.
  always_comb begin
    // NOTE: assign a default first so no path leaves stall_o unassigned
    // (which would infer a latch).
    stall_o = STALL_NONE;
    if (mem_req_i && !mem_ack_o) begin
      stall_o = STALL_MEM;
    end else if (if_req_i && !if_ack_o) begin
      stall_o = STALL_IF;
    end
  end

endmodule

// File: tb/tb_pipe_bus_arbiter.sv
// Directed self-checking bench for pipe_bus_arbiter. Inputs change 1 ns after
// the rising edge; outputs are sampled before the next rising edge.
module tb_pipe_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_i;
  logic        bus_ack_i;
  logic [5:0]  stall_o;
  logic        bus_err_o;

  int total;
  int bad;

  // Values last delivered to each port, tracked by the bench.
  logic [31:0] exp_if_data;
  logic [31:0] exp_mem_data;

  pipe_bus_arbiter #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req_i  (if_req_i),
    .if_addr_i (if_addr_i),
    .if_data_o (if_data_o),
    .if_ack_o  (if_ack_o),
    .mem_req_i (mem_req_i),
    .mem_we_i  (mem_we_i),
    .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i),
    .mem_sel_i (mem_sel_i),
    .mem_data_o(mem_data_o),
    .mem_ack_o (mem_ack_o),
    .bus_cyc_o (bus_cyc_o),
    .bus_stb_o (bus_stb_o),
    .bus_we_o  (bus_we_o),
    .bus_addr_o(bus_addr_o),
    .bus_data_o(bus_data_o),
    .bus_sel_o (bus_sel_o),
    .bus_data_i(bus_data_i),
    .bus_ack_i (bus_ack_i),
    .stall_o   (stall_o),
    .bus_err_o (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    total++;
    if ({bus_cyc_o, bus_stb_o, if_ack_o, mem_ack_o, bus_err_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000",
               {bus_cyc_o, bus_stb_o, if_ack_o, mem_ack_o, bus_err_o});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    // Start a store, then pull reset between edges while it waits.
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h80;
    mem_data_i = 32'h1; mem_sel_i = 4'hF;
    tick();
    total++;
    if (bus_cyc_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_grant: cyc got %b want 1", bus_cyc_o);
    end
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({bus_cyc_o, bus_stb_o} !== 2'b00) begin
      bad++;
      $display("FAIL reset_async_cyc: got %b want 00", {bus_cyc_o, bus_stb_o});
    end
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
    mem_data_i = '0; mem_sel_i = '0;
    tick();
    rst = 1'b1;
    tick();
    total++;
    if ({bus_we_o, bus_addr_o, bus_data_o, bus_sel_o} !== 69'd0) begin
      bad++;
      $display("FAIL reset_bus_fields: we=%b addr=%h data=%h sel=%h want all 0",
               bus_we_o, bus_addr_o, bus_data_o, bus_sel_o);
    end
    total++;
    if ({if_data_o, mem_data_o, stall_o, bus_cyc_o, bus_err_o} !== 72'd0) begin
      bad++;
      $display("FAIL reset_outputs: ifd=%h memd=%h stall=%b cyc=%b err=%b want all 0",
               if_data_o, mem_data_o, stall_o, bus_cyc_o, bus_err_o);
    end
    exp_if_data  = '0;
    exp_mem_data = '0;
  endtask

  task automatic test_store();
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h100;
    mem_data_i = 32'hDEADBEEF; mem_sel_i = 4'b0011;
    #1;
    total++;
    if (stall_o !== 6'b011111) begin
      bad++;
      $display("FAIL store_stall_req: got %b want 011111", stall_o);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o} !==
          {3'b111, 32'h100, 32'hDEADBEEF, 4'b0011}) begin
        bad++;
        $display("FAIL store_bus_c%0d: cyc=%b stb=%b we=%b addr=%h data=%h sel=%b want 1 1 1 00000100 deadbeef 0011",
                 c, bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o);
      end
      total++;
      if ({stall_o, mem_ack_o} !== {6'b011111, 1'b0}) begin
        bad++;
        $display("FAIL store_wait_c%0d: stall=%b ack=%b want 011111 0", c, stall_o, mem_ack_o);
      end
      if (c == 2) begin
        bus_ack_i = 1'b1; bus_data_i = 32'h12345678;
      end
      tick();
    end
    bus_ack_i = 1'b0; bus_data_i = '0;
    exp_mem_data = 32'h0;
    total++;
    if ({mem_ack_o, mem_data_o, bus_cyc_o, stall_o} !== {1'b1, exp_mem_data, 1'b0, 6'b0}) begin
      bad++;
      $display("FAIL store_done: ack=%b data=%h cyc=%b stall=%b want 1 %h 0 000000",
               mem_ack_o, mem_data_o, bus_cyc_o, stall_o, exp_mem_data);
    end
    mem_req_i = 1'b0; mem_we_i = 1'b0;
    tick();
    total++;
    if (mem_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL store_ack_pulse: got %b want 0", mem_ack_o);
    end
  endtask

  task automatic test_fetch();
    if_req_i = 1'b1; if_addr_i = 32'h10;
    #1;
    total++;
    if (stall_o !== 6'b000011) begin
      bad++;
      $display("FAIL fetch_stall_req: got %b want 000011", stall_o);
    end
    tick();
    total++;
    if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o} !==
        {3'b110, 32'h10, 32'h0, 4'hF}) begin
      bad++;
      $display("FAIL fetch_bus: cyc=%b stb=%b we=%b addr=%h data=%h sel=%h want 1 1 0 00000010 0 f",
               bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o);
    end
    for (int c = 0; c < 3; c++) begin
      total++;
      if ({stall_o, if_ack_o} !== {6'b000011, 1'b0}) begin
        bad++;
        $display("FAIL fetch_wait_c%0d: stall=%b ack=%b want 000011 0", c, stall_o, if_ack_o);
      end
      if (c == 2) begin
        bus_ack_i = 1'b1; bus_data_i = 32'h3401FF00;
      end
      tick();
    end
    bus_ack_i = 1'b0; bus_data_i = '0;
    exp_if_data = 32'h3401FF00;
    total++;
    if ({if_ack_o, if_data_o, bus_cyc_o, stall_o} !== {1'b1, exp_if_data, 1'b0, 6'b0}) begin
      bad++;
      $display("FAIL fetch_done: ack=%b data=%h cyc=%b stall=%b want 1 %h 0 000000",
               if_ack_o, if_data_o, bus_cyc_o, stall_o, exp_if_data);
    end
    if_req_i = 1'b0;
    tick();
    total++;
    if ({if_ack_o, if_data_o} !== {1'b0, exp_if_data}) begin
      bad++;
      $display("FAIL fetch_hold: ack=%b data=%h want 0 %h", if_ack_o, if_data_o, exp_if_data);
    end
  endtask

  task automatic test_back_to_back();
    // Last completed access was a fetch, so the data port goes first.
    logic exp_mem [4];
    exp_mem[0] = 1'b1; exp_mem[1] = 1'b0; exp_mem[2] = 1'b1; exp_mem[3] = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h20;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h200;
    mem_data_i = 32'h0; mem_sel_i = 4'hF;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if ({bus_cyc_o, bus_addr_o} !== {1'b1, (exp_mem[k] ? 32'h200 : 32'h20)}) begin
        bad++;
        $display("FAIL b2b_grant%0d: cyc=%b addr=%h want 1 %h", k, bus_cyc_o, bus_addr_o,
                 (exp_mem[k] ? 32'h200 : 32'h20));
      end
      total++;
      if (stall_o !== 6'b011111) begin
        bad++;
        $display("FAIL b2b_stall%0d: got %b want 011111", k, stall_o);
      end
      bus_ack_i = 1'b1; bus_data_i = 32'hA0000000 + 32'(k);
      tick();
      bus_ack_i = 1'b0; bus_data_i = '0;
      if (exp_mem[k]) exp_mem_data = 32'hA0000000 + 32'(k);
      else            exp_if_data  = 32'hA0000000 + 32'(k);
      total++;
      if ({bus_cyc_o, mem_ack_o, if_ack_o, mem_data_o, if_data_o} !==
          {1'b0, exp_mem[k], ~exp_mem[k], exp_mem_data, exp_if_data}) begin
        bad++;
        $display("FAIL b2b_done%0d: cyc=%b mack=%b iack=%b md=%h id=%h want 0 %b %b %h %h",
                 k, bus_cyc_o, mem_ack_o, if_ack_o, mem_data_o, if_data_o,
                 exp_mem[k], ~exp_mem[k], exp_mem_data, exp_if_data);
      end
    end
    if_req_i = 1'b0; mem_req_i = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    if_req_i = 1'b1; if_addr_i = 32'h40;
    tick();
    tick();
    if_req_i = 1'b0;
    #1;
    total++;
    if ({bus_cyc_o, stall_o} !== {1'b1, 6'b0}) begin
      bad++;
      $display("FAIL flush_wait: cyc=%b stall=%b want 1 000000", bus_cyc_o, stall_o);
    end
    tick();
    bus_ack_i = 1'b1; bus_data_i = 32'h55555555;
    tick();
    bus_ack_i = 1'b0; bus_data_i = '0;
    total++;
    if ({bus_cyc_o, if_ack_o, if_data_o} !== {1'b0, 1'b0, exp_if_data}) begin
      bad++;
      $display("FAIL flush_done: cyc=%b ack=%b data=%h want 0 0 %h",
               bus_cyc_o, if_ack_o, if_data_o, exp_if_data);
    end
  endtask

  task automatic test_idle_ack();
    bus_ack_i = 1'b1; bus_data_i = 32'hFFFFFFFF;
    tick();
    tick();
    bus_ack_i = 1'b0; bus_data_i = '0;
    total++;
    if ({bus_cyc_o, if_ack_o, mem_ack_o, if_data_o, mem_data_o} !==
        {3'b000, exp_if_data, exp_mem_data}) begin
      bad++;
      $display("FAIL idle_ack: cyc=%b iack=%b mack=%b id=%h md=%h want 0 0 0 %h %h",
               bus_cyc_o, if_ack_o, mem_ack_o, if_data_o, mem_data_o, exp_if_data, exp_mem_data);
    end
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h300; mem_sel_i = 4'hF;
    tick();
    repeat (3) tick();
    total++;
    if ({bus_cyc_o, bus_err_o, mem_ack_o} !== 3'b100) begin
      bad++;
      $display("FAIL tmo_wait4: cyc=%b err=%b ack=%b want 1 0 0", bus_cyc_o, bus_err_o, mem_ack_o);
    end
    tick();
    exp_mem_data = 32'h0;
    total++;
    if ({bus_cyc_o, bus_err_o, mem_ack_o, mem_data_o} !== {3'b011, exp_mem_data}) begin
      bad++;
      $display("FAIL tmo_fire: cyc=%b err=%b ack=%b data=%h want 0 1 1 0",
               bus_cyc_o, bus_err_o, mem_ack_o, mem_data_o);
    end
    mem_req_i = 1'b0;
    tick();
    total++;
    if ({bus_err_o, mem_ack_o} !== 2'b00) begin
      bad++;
      $display("FAIL tmo_pulse: err=%b ack=%b want 0 0", bus_err_o, mem_ack_o);
    end
    mem_req_i = 1'b1;
    tick();
    repeat (3) tick();
    bus_ack_i = 1'b1; bus_data_i = 32'h00000077;
    tick();
    bus_ack_i = 1'b0; bus_data_i = '0;
    exp_mem_data = 32'h77;
    total++;
    if ({bus_cyc_o, bus_err_o, mem_ack_o, mem_data_o} !== {3'b001, exp_mem_data}) begin
      bad++;
      $display("FAIL tmo_ack_wins: cyc=%b err=%b ack=%b data=%h want 0 0 1 %h",
               bus_cyc_o, bus_err_o, mem_ack_o, mem_data_o, exp_mem_data);
    end
    mem_req_i = 1'b0;
    tick();
  endtask
`else
  task automatic test_timeout();
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h300; mem_sel_i = 4'hF;
    tick();
    repeat (10) tick();
    total++;
    if ({bus_cyc_o, bus_err_o, mem_ack_o} !== 3'b100) begin
      bad++;
      $display("FAIL unbounded_wait: cyc=%b err=%b ack=%b want 1 0 0",
               bus_cyc_o, bus_err_o, mem_ack_o);
    end
    bus_ack_i = 1'b1; bus_data_i = 32'h00000077;
    tick();
    bus_ack_i = 1'b0; bus_data_i = '0;
    exp_mem_data = 32'h77;
    total++;
    if ({bus_cyc_o, bus_err_o, mem_ack_o, mem_data_o} !== {3'b001, exp_mem_data}) begin
      bad++;
      $display("FAIL unbounded_done: cyc=%b err=%b ack=%b data=%h want 0 0 1 %h",
               bus_cyc_o, bus_err_o, mem_ack_o, mem_data_o, exp_mem_data);
    end
    mem_req_i = 1'b0;
    tick();
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0;
    mem_data_i = '0; mem_sel_i = '0;
    bus_data_i = '0; bus_ack_i = 1'b0;
    exp_if_data = '0; exp_mem_data = '0;
    test_reset();
    test_store();
    test_fetch();
    test_back_to_back();
    test_flush();
    test_idle_ack();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
